div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
- REQ-001 Parameter WIDTH, default 32, operand width in bits.
- REQ-002 clk  in  1  sole clock; all state updates on rising edge.
- REQ-003 resetn  in  1  reset; asynchronous, active-low.
- REQ-004 start_i  in  1  divide instruction present in E stage; held high while E is stalled.
- REQ-005 signed_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- REQ-006 opa_i  in  WIDTH  dividend.
- REQ-007 opb_i  in  WIDTH  divisor.
- REQ-008 cancel_i  in  1  abort request; E-stage instruction is being flushed.
- REQ-009 stall_o  out  1  pipeline stall request; drives the hazard unit's div_stallE.
- REQ-010 done_o  out  1  one-cycle pulse; result_o valid this cycle.
- REQ-011 result_o  out  2*WIDTH  {hi = remainder, lo = quotient}.

Function
- REQ-012 States: IDLE, CALC, DONE.
- REQ-013 IDLE with start_i=1, cancel_i=0 and opb_i!=0: latch opa_i, opb_i and signed_i; load the iteration counter with WIDTH; go to CALC.
- REQ-014 IDLE with start_i=1, cancel_i=0 and opb_i==0: go directly to DONE; result = {hi=opa_i, lo=all ones}.
- REQ-015 CALC: perform one restoring shift-subtract step per cycle on the operand magnitudes; decrement the counter; after WIDTH steps go to DONE.
- REQ-016 DONE: assert done_o, update result_o, go to IDLE unconditionally next cycle.
- REQ-017 DONE always returns to IDLE, even if start_i is still high, so the same instruction is never restarted; start_i seen in IDLE after DONE is a new instruction (back-to-back divides are legal).
- REQ-018 stall_o = ~cancel_i & ((IDLE & start_i) | CALC); combinational, low in DONE.
- REQ-019 Latency for a nonzero divisor: stall_o high for WIDTH+1 consecutive cycles; done_o in the cycle immediately after.
- REQ-020 Latency for a zero divisor: stall_o high for 1 cycle; done_o in the next cycle.
- REQ-021 Signed mode: divide the absolute values; negate the quotient when the operand signs differ; the remainder takes the sign of the dividend.
- REQ-022 Signed overflow (most-negative / -1): quotient = most-negative value, remainder = 0, with no special casing beyond the magnitude arithmetic.
- REQ-023 Operand or signed_i changes during CALC shall be ignored.
- REQ-024 cancel_i=1 in any state: go to IDLE next cycle; done_o stays 0; result_o is unchanged; stall_o is forced low in the same cycle.
- REQ-025 result_o holds its last value between DONE cycles.

Reset
- REQ-026 resetn low, asynchronously: state=IDLE, counter=0, latched operands=0, result_o=0, done_o=0, stall_o=0.
- REQ-027 Reset during CALC discards the operation; no done_o follows reset release.

Structure
- REQ-028 The state encoding and a DIV_WIDTH default constant shall live in the shared cpu package (mycpu_pkg).
- REQ-029 One combinational sub-module, div_step, implements a single shift-subtract iteration (partial remainder, quotient bit); div_seq instantiates it once.

Verification
- REQ-030 Unsigned: opa=100, opb=7 -> stall_o high 33 cycles, then done_o with lo=14, hi=2.
- REQ-031 Signed: opa=-7, opb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; opa=7, opb=-2 -> lo=0xFFFFFFFD, hi=1.
- REQ-032 Zero divisor: opa=0x1234, opb=0 -> 1 stall cycle, then done_o with hi=0x1234, lo=0xFFFFFFFF.
- REQ-033 Cancel: cancel_i pulsed on CALC cycle 10 -> stall_o low that cycle, IDLE next cycle, no done_o; result_o keeps its previous value.
- REQ-034 Back-to-back: 100/7 then 9/4 with start_i continuous -> two done_o pulses 34 cycles apart; results 14/2, then 2/1.
- REQ-035 Reset: resetn deasserted mid-CALC -> outputs 0 immediately; no done_o after release.

Source files
------------

// File: rtl/mycpu_pkg.sv
// mycpu_pkg -- shared CPU definitions.
//
// Holds the divider FSM state encoding and the default divider operand
// width, so the hazard unit and any other consumer can refer to the
// same encoding as the divider itself.
package mycpu_pkg;

  // Default operand width of the sequential divider.
  localparam int DIV_WIDTH = 32;

  // Divider control states.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage : mycpu_pkg

// File: rtl/div_step.sv
// div_step -- one restoring shift-subtract division iteration (combinational).
//
// Ports:
//   rem       in  WIDTH  current partial remainder (always < dsr)
//   dvd_msb   in  1      next dividend bit shifted into the remainder
//   dsr       in  WIDTH  divisor magnitude (nonzero)
//   rem_next  out WIDTH  partial remainder after this step
//   q_bit     out 1      quotient bit produced by this step
module div_step
  import mycpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem, dvd_msb};
    diff    = shifted - {1'b0, dsr};
    // Because rem < dsr, shifted < 2*dsr: the top bit of diff is a clean
    // borrow flag, and whichever value is kept fits back into WIDTH bits.
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule : div_step

// File: rtl/div_seq.sv
// div_seq -- multi-cycle signed/unsigned integer divider for the E stage.
//
// A restoring divider that produces one quotient bit per cycle on operand
// magnitudes, then applies the sign rules when the result is presented.
//
// Ports:
//   clk       in  1        clock, rising edge
//   resetn    in  1        asynchronous active-low reset
//   start_i   in  1        divide present in E; held while E is stalled
//   signed_i  in  1        1 = DIV (two's complement), 0 = DIVU
//   opa_i     in  WIDTH    dividend
//   opb_i     in  WIDTH    divisor
//   cancel_i  in  1        flush of the E-stage instruction
//   stall_o   out 1        stall request to the hazard unit (combinational)
//   done_o    out 1        one-cycle pulse, result_o valid
//   result_o  out 2*WIDTH  {remainder, quotient}; holds between completions
module div_seq
  import mycpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic               cancel_i,
  output logic               stall_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e         state;
  div_state_e         state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic               signed_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;    // dividend bits shift out, quotient bits shift in
  logic [2*WIDTH-1:0] result_q;

  logic               accept;
  logic               neg_a_in;
  logic [WIDTH-1:0]   mag_a_in;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] final_result;

  assign accept = (state == DIV_IDLE) && start_i && !cancel_i;

  // Dividend magnitude is taken at acceptance so the shift register starts
  // directly on it; the divisor magnitude is derived from the latched copy.
  assign neg_a_in = signed_i & opa_i[WIDTH-1];
  assign mag_a_in = neg_a_in ? -opa_i : opa_i;

  assign neg_a = signed_q & opa_q[WIDTH-1];
  assign neg_b = signed_q & opb_q[WIDTH-1];
  assign mag_b = neg_b ? -opb_q : opb_q;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_q),
    .dvd_msb  (quo_q[WIDTH-1]),
    .dsr      (mag_b),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Most-negative / -1 needs no special case: the magnitude quotient is
  // already the most-negative bit pattern and the signs agree.
  assign quo_fix = (neg_a ^ neg_b) ? -quo_q : quo_q;
  assign rem_fix = neg_a ? -rem_q : rem_q;

  // A zero divisor bypasses CALC, so the latched operands alone define it.
  assign final_result = (opb_q == '0) ? {opa_q, {WIDTH{1'b1}}}
                                      : {rem_fix, quo_fix};

  // NOTE: every output of this block is assigned a default first, so no
  // path through the case statement can leave a value held (no latches).
  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    done_o     = 1'b0;
    result_o   = result_q;

    case (state)
      DIV_IDLE: if (start_i) state_next = (opb_i == '0) ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt == CNT_W'(1)) state_next = DIV_DONE;
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase

    if (cancel_i) state_next = DIV_IDLE;

    // resetn gating keeps the stall request low while reset is held, even
    // if the pipeline still presents start_i.
    stall_o = resetn & ~cancel_i &
              (((state == DIV_IDLE) & start_i) | (state == DIV_CALC));
    done_o  = (state == DIV_DONE) & ~cancel_i;
    if (done_o) result_o = final_result;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      signed_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        opa_q    <= opa_i;
        opb_q    <= opb_i;
        signed_q <= signed_i;
        cnt      <= CNT_W'(WIDTH);
        rem_q    <= '0;
        quo_q    <= mag_a_in;
      end else if ((state == DIV_CALC) && !cancel_i) begin
        rem_q <= rem_next;
        quo_q <= {quo_q[WIDTH-2:0], q_bit};
        cnt   <= cnt - 1'b1;
      end

      if (done_o) result_q <= final_result;
    end
  end

endmodule : div_seq
